// File: rtl/stream_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_accumulator_if
// Brief    : Operand-beat input stream and packet-result output stream
//            bundled for the stream accumulator.
// Revision : 1.0 - initial release
// ============================================================================
interface stream_accumulator_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_overflow;

    // Producer of operand beats and consumer of results
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_overflow
    );

    // The accumulator itself
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_overflow
    );
endinterface
`default_nettype wire

// File: rtl/stream_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : stream_accumulator
// Brief    : Sums a variable-length packet of signed operands into a wider
//            accumulator and returns one result per packet with beat count
//            and a sticky overflow flag. Saturating or wrapping add.
// Revision : 1.0 - initial release
// ============================================================================
module stream_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 8,
    parameter bit SATURATE  = 1'b1
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               clear,
    stream_accumulator_if.slave     bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic signed [ACC_WIDTH-1:0] c_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]        c_CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]        c_CNT_ONE = CNT_WIDTH'(1);

    state_t                      r_state;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0]        r_count;
    logic                        r_ovf;
    logic                        r_in_ready;
    logic                        r_out_valid;

    logic signed [WIDTH-1:0]     w_in;
    logic signed [ACC_WIDTH-1:0] w_ext;
    logic signed [ACC_WIDTH:0]   w_sum;
    logic                        w_add_ovf;
    logic signed [ACC_WIDTH-1:0] w_add_res;
    logic                        w_beat;
    logic                        w_take;

    assign w_in   = bus.in_data;
    assign w_ext  = ACC_WIDTH'(w_in);
    assign w_beat = bus.in_valid && r_in_ready;
    assign w_take = r_out_valid && bus.out_ready;

    // One guard bit: the top two bits of the widened sum disagree on overflow
    assign w_sum     = (ACC_WIDTH+1)'(r_acc) + (ACC_WIDTH+1)'(w_ext);
    assign w_add_ovf = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

    generate
        if (SATURATE) begin : g_saturate
            // The guard bit holds the true sign, so it picks the clamp rail
            assign w_add_res = w_add_ovf ? (w_sum[ACC_WIDTH] ? c_ACC_MIN : c_ACC_MAX)
                                         : w_sum[ACC_WIDTH-1:0];
        end else begin : g_wrap
            assign w_add_res = w_sum[ACC_WIDTH-1:0];
        end
    endgenerate

    // Packet FSM; handshake flags are registered alongside the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Raises in_ready on the first edge after reset release
                    r_in_ready <= 1'b1;
                    if (w_beat) begin
                        r_acc   <= w_ext;
                        r_count <= c_CNT_ONE;
                        r_ovf   <= 1'b0;
                        if (bus.in_last) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_beat) begin
                        r_acc   <= w_add_res;
                        r_count <= (r_count == c_CNT_MAX) ? r_count : r_count + c_CNT_ONE;
                        r_ovf   <= r_ovf | w_add_ovf;
                        if (bus.in_last) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (w_take) begin
                        r_state     <= S_IDLE;
                        r_acc       <= '0;
                        r_count     <= '0;
                        r_ovf       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_acc;
    assign bus.out_count    = r_count;
    assign bus.out_overflow = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_stream_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_accumulator
// Brief    : Self-checking bench. Three accumulators share one stimulus
//            stream: A = default widths/saturating, B = 8-bit saturating with
//            a 3-bit counter, C = 8-bit wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_accumulator;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    int total = 0;
    int bad   = 0;
    int pkt[$];

    always #5 clk = ~clk;

    stream_accumulator_if #(.WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8)) ifa ();
    stream_accumulator_if #(.WIDTH(8), .ACC_WIDTH(8),  .CNT_WIDTH(3)) ifb ();
    stream_accumulator_if #(.WIDTH(8), .ACC_WIDTH(8),  .CNT_WIDTH(8)) ifc ();

    assign ifa.in_valid = in_valid; assign ifb.in_valid = in_valid; assign ifc.in_valid = in_valid;
    assign ifa.in_data  = in_data;  assign ifb.in_data  = in_data;  assign ifc.in_data  = in_data;
    assign ifa.in_last  = in_last;  assign ifb.in_last  = in_last;  assign ifc.in_last  = in_last;
    assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready; assign ifc.out_ready = out_ready;

    stream_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8), .SATURATE(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifa));
    stream_accumulator #(.WIDTH(8), .ACC_WIDTH(8), .CNT_WIDTH(3), .SATURATE(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifb));
    stream_accumulator #(.WIDTH(8), .ACC_WIDTH(8), .CNT_WIDTH(8), .SATURATE(1'b0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifc));

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: integer sum of the packet with range checking after each add
    function automatic longint model_sum(input int accw, input bit sat, output bit ovf);
        longint lo, hi, s, t;
        hi  = (longint'(1) <<< (accw - 1)) - 1;
        lo  = -(longint'(1) <<< (accw - 1));
        ovf = 1'b0;
        s   = pkt[0];
        for (int i = 1; i < pkt.size(); i++) begin
            t = s + pkt[i];
            if (t > hi || t < lo) begin
                ovf = 1'b1;
                if (sat) t = (t > hi) ? hi : lo;
                else     t = (t > hi) ? t - (hi - lo + 1) : t + (hi - lo + 1);
            end
            s = t;
        end
        return s;
    endfunction

    function automatic longint model_count(input int cntw);
        longint m;
        m = (longint'(1) <<< cntw) - 1;
        return (pkt.size() > m) ? m : longint'(pkt.size());
    endfunction

    // Present every beat of pkt, with random idle gaps carrying junk data
    task automatic drive_beats(input bit mark_last);
        foreach (pkt[i]) begin
            repeat ($urandom_range(0, 1)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = 8'(pkt[i]);
            in_last  = mark_last && (i == pkt.size() - 1);
            chk("beat_in_ready", longint'(ifa.in_ready), 1);
            chk("no_early_valid", longint'(ifa.out_valid), 0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic check_outputs();
        bit     ovf;
        longint s;
        chk("valid_a", longint'(ifa.out_valid), 1);
        chk("valid_b", longint'(ifb.out_valid), 1);
        chk("valid_c", longint'(ifc.out_valid), 1);
        s = model_sum(16, 1'b1, ovf);
        chk("data_a", longint'($signed(ifa.out_data)), s);
        chk("ovf_a", longint'(ifa.out_overflow), longint'(ovf));
        chk("count_a", longint'(ifa.out_count), model_count(8));
        s = model_sum(8, 1'b1, ovf);
        chk("data_b", longint'($signed(ifb.out_data)), s);
        chk("ovf_b", longint'(ifb.out_overflow), longint'(ovf));
        chk("count_b", longint'(ifb.out_count), model_count(3));
        s = model_sum(8, 1'b0, ovf);
        chk("data_c", longint'($signed(ifc.out_data)), s);
        chk("ovf_c", longint'(ifc.out_overflow), longint'(ovf));
        chk("count_c", longint'(ifc.out_count), model_count(8));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("consumed_valid", longint'(ifa.out_valid), 0);
        chk("idle_in_ready", longint'(ifa.in_ready), 1);
    endtask

    task automatic run_packet();
        drive_beats(1'b1);
        check_outputs();
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(ifa.in_ready), 0);
        chk("rst_out_valid", longint'(ifa.out_valid), 0);
        chk("rst_out_data", longint'(ifa.out_data), 0);
        chk("rst_out_count", longint'(ifa.out_count), 0);
        chk("rst_out_ovf", longint'(ifa.out_overflow), 0);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", longint'(ifa.in_ready), 0);
        @(posedge clk); #1;
        chk("first_edge_in_ready", longint'(ifa.in_ready), 1);

        // Directed packets: basic, single beat, negatives, clamp, wrap, min rail, count saturation
        pkt = '{2, 3};              run_packet();
        pkt = '{12};                run_packet();
        pkt = '{-1, 1};             run_packet();
        pkt = '{100, 100, -50};     run_packet();
        pkt = '{100, 100};          run_packet();
        pkt = '{-128, -128, -128, 5}; run_packet();
        pkt = '{127, 127, 127, 127, 127, 127, 127, 127, 127, 127}; run_packet();

        // Backpressure: result held, inputs refused
        out_ready = 1'b0;
        pkt = '{5, 6};
        drive_beats(1'b1);
        check_outputs();
        repeat (5) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk); #1;
            chk("bp_in_ready", longint'(ifa.in_ready), 0);
            check_outputs();
        end
        in_valid = 1'b0; in_last = 1'b0;
        consume();

        // clear while a result is pending discards it
        out_ready = 1'b0;
        pkt = '{4};
        drive_beats(1'b1);
        chk("pend_valid", longint'(ifa.out_valid), 1);
        clear = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_done_valid", longint'(ifa.out_valid), 0);
        chk("clr_done_data", longint'(ifa.out_data), 0);
        chk("clr_done_in_ready", longint'(ifa.in_ready), 1);
        out_ready = 1'b1;

        // clear mid-packet with a simultaneous beat that must be dropped
        pkt = '{7, 9};
        drive_beats(1'b0);
        clear = 1'b1; in_valid = 1'b1; in_data = 8'd55; in_last = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("clr_valid", longint'(ifa.out_valid), 0);
        chk("clr_data", longint'(ifa.out_data), 0);
        chk("clr_count", longint'(ifa.out_count), 0);
        chk("clr_in_ready", longint'(ifa.in_ready), 1);
        pkt = '{0, 1};              run_packet();

        // Asynchronous reset mid-packet
        pkt = '{7, 9};
        drive_beats(1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", longint'(ifa.in_ready), 0);
        chk("arst_data", longint'(ifa.out_data), 0);
        chk("arst_count", longint'(ifa.out_count), 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_rec_in_ready", longint'(ifa.in_ready), 1);
        chk("arst_rec_valid", longint'(ifa.out_valid), 0);
        pkt = '{0, 1};              run_packet();

        // Random packets against the reference
        repeat (25) begin
            int n;
            n = $urandom_range(1, 12);
            pkt.delete();
            for (int i = 0; i < n; i++) pkt.push_back(int'($signed(8'($urandom))));
            run_packet();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
